// File: rtl/axis_fifo_reg.sv
// Registered AXI-stream FIFO: one output register backed by a (DEPTH-1)-entry ring.
// Every output is a flop, so the block can sit between stages as an elastic timing-closure buffer.
module axis_fifo_reg #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  (* X_INTERFACE_PARAMETER = "POLARITY ACTIVE_HIGH" *)
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic [DATA_WIDTH-1:0]  m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam int RING_DEPTH = DEPTH - 1;
  localparam int PTR_WIDTH  = (RING_DEPTH > 1) ? $clog2(RING_DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0]   PTR_LAST   = PTR_WIDTH'(RING_DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_FULL = COUNT_WIDTH'(DEPTH);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0]  ring [RING_DEPTH];
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [COUNT_WIDTH-1:0] count_next;

  logic push;
  logic pop;
  logic load_en;
  logic ring_empty;
  logic ring_rd;
  logic bypass;
  logic ring_wr;

  // Explicit wrap so non-power-of-two ring depths never rely on binary overflow.
  function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PTR_WIDTH'(1);
  endfunction

  assign push    = s_tvalid && s_tready;
  assign pop     = m_tvalid && m_tready;
  assign load_en = !m_tvalid || m_tready;

  // The output register holds one word whenever count != 0, so the ring holds count-1.
  assign ring_empty = (count <= COUNT_ONE);
  assign ring_rd    = load_en && !ring_empty;
  assign bypass     = load_en && ring_empty && push;
  assign ring_wr    = push && !bypass;

  always_comb begin
    // NOTE: defaulting every always_comb output first rules out an inferred latch.
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + COUNT_ONE;
      2'b01:   count_next = count - COUNT_ONE;
      default: count_next = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      m_tvalid <= 1'b0;
      s_tready <= 1'b1;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      count    <= count_next;
      m_tvalid <= (count_next != '0);
      s_tready <= (count_next < COUNT_FULL);
      if (ring_rd) rd_ptr <= next_ptr(rd_ptr);
      if (ring_wr) wr_ptr <= next_ptr(wr_ptr);
    end
  end

  // NOTE: payload storage is deliberately not reset; m_tvalid qualifies m_tdata and
  // the pointers qualify the ring, so clearing the data would only add reset fan-out.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (ring_wr) ring[wr_ptr] <= s_tdata;
      if (ring_rd) begin
        m_tdata <= ring[rd_ptr];
      end else if (bypass) begin
        m_tdata <= s_tdata;
      end
    end
  end

  a_valid_tracks_count : assert property (@(posedge clock) disable iff (reset)
    m_tvalid == (count != '0));
  a_ready_tracks_count : assert property (@(posedge clock) disable iff (reset)
    s_tready == (count != COUNT_FULL));
  a_full_implies_valid : assert property (@(posedge clock) disable iff (reset)
    !s_tready |-> m_tvalid);

endmodule

// File: tb/tb_axis_fifo_reg.sv
// Bench for axis_fifo_reg: three instances (DEPTH 4, 3, 2) driven by directed vectors;
// a single negedge monitor compares flags/count to a count model and data to a scoreboard.
module tb_axis_fifo_reg;

  localparam int NL         = 3;
  localparam int N_RAND     = 10000;
  localparam int MAX_CYCLES = 80000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] s_tdata  [NL];
  logic       s_tvalid [NL];
  logic       s_tready [NL];
  logic [7:0] m_tdata  [NL];
  logic       m_tvalid [NL];
  logic       m_tready [NL];
  logic [2:0] count    [NL];

  logic [7:0] exp_q [NL][$];
  int         cnt_m [NL];
  int         checks   = 0;
  int         failures = 0;
  int         ncycles  = 0;
  logic       done     = 1'b0;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int D  = (g == 0) ? 4 : (g == 1) ? 3 : 2;
    localparam int CW = $clog2(D + 1);
    logic [CW-1:0] cnt;

    axis_fifo_reg #(.DATA_WIDTH(8), .DEPTH(D)) dut (
      .clock    (clk),
      .reset    (reset),
      .s_tdata  (s_tdata[g]),
      .s_tvalid (s_tvalid[g]),
      .s_tready (s_tready[g]),
      .m_tdata  (m_tdata[g]),
      .m_tvalid (m_tvalid[g]),
      .m_tready (m_tready[g]),
      .count    (cnt)
    );

    assign count[g] = 3'(cnt);
  end

  function automatic int lane_depth(input int g);
    return (g == 0) ? 4 : (g == 1) ? 3 : 2;
  endfunction

  function automatic logic [7:0] rand_word(input int i);
    return 8'((i * 37) + 5);
  endfunction

  task automatic check(input string name, input int lane, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s lane=%0d cycle=%0d actual=%0h required=%0h",
               name, lane, ncycles, act, req);
    end
  endtask

  // Monitor: outputs reflect state after the last posedge; inputs are those for the next one.
  always @(negedge clk) begin
    ncycles++;
    for (int g = 0; g < NL; g++) begin
      int   d;
      logic ev;
      logic er;
      logic mpush;
      logic mpop;
      d  = lane_depth(g);
      ev = (cnt_m[g] != 0);
      er = (cnt_m[g] != d);
      check("m_tvalid", g, 32'(m_tvalid[g]), 32'(ev));
      check("s_tready", g, 32'(s_tready[g]), 32'(er));
      check("count",    g, 32'(count[g]),    32'(cnt_m[g]));
      if (ev) begin
        if (exp_q[g].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL m_tdata lane=%0d cycle=%0d actual=%0h required=none outstanding",
                   g, ncycles, m_tdata[g]);
        end else begin
          check("m_tdata", g, 32'(m_tdata[g]), 32'(exp_q[g][0]));
        end
      end
      if (reset) begin
        cnt_m[g] = 0;
        exp_q[g].delete();
      end else begin
        mpush = s_tvalid[g] && er;
        mpop  = ev && m_tready[g];
        if (mpop && exp_q[g].size() != 0) void'(exp_q[g].pop_front());
        cnt_m[g] = cnt_m[g] + int'(mpush) - int'(mpop);
      end
    end
    if (done) begin
      for (int g = 0; g < NL; g++) check("drained", g, 32'(exp_q[g].size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end else if (ncycles >= MAX_CYCLES) begin
      checks++;
      failures++;
      $display("FAIL watchdog cycle=%0d actual=running required=finished", ncycles);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int g, input logic v, input logic [7:0] d, input logic r);
    s_tvalid[g] = v;
    s_tdata[g]  = d;
    m_tready[g] = r;
  endtask

  initial begin
    int idx;
    reset = 1'b1;
    for (int g = 0; g < NL; g++) begin
      drive(g, 1'b0, 8'h00, 1'b0);
      cnt_m[g] = 0;
    end
    tick();
    tick();
    reset = 1'b0;

    // Pass-through: each word appears one cycle after acceptance, count stays at most 1.
    exp_q[0].push_back(8'h11);
    exp_q[0].push_back(8'h22);
    exp_q[0].push_back(8'h33);
    drive(0, 1'b1, 8'h11, 1'b1); tick();
    drive(0, 1'b1, 8'h22, 1'b1); tick();
    drive(0, 1'b1, 8'h33, 1'b1); tick();
    drive(0, 1'b0, 8'h00, 1'b1); repeat (3) tick();

    // Fill with the sink stalled: 1..4 accepted, 5 held off while full.
    for (int i = 1; i <= 6; i++) exp_q[0].push_back(8'(i));
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1'b1, 8'(i), 1'b0);
      tick();
    end
    drive(0, 1'b1, 8'h05, 1'b0); repeat (3) tick();

    // Drain from full: first pop frees a slot, 5 enters next cycle, then 6.
    drive(0, 1'b1, 8'h05, 1'b1); tick();
    drive(0, 1'b1, 8'h05, 1'b1); tick();
    drive(0, 1'b1, 8'h06, 1'b1); tick();
    drive(0, 1'b0, 8'h00, 1'b1); repeat (4) tick();

    // Mid-stream reset discards three held words and an offered fourth.
    exp_q[0].push_back(8'h31);
    exp_q[0].push_back(8'h32);
    exp_q[0].push_back(8'h33);
    drive(0, 1'b1, 8'h31, 1'b0); tick();
    drive(0, 1'b1, 8'h32, 1'b0); tick();
    drive(0, 1'b1, 8'h33, 1'b0); tick();
    drive(0, 1'b1, 8'h34, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q[0].push_back(8'hAA);
    drive(0, 1'b1, 8'hAA, 1'b1); tick();
    drive(0, 1'b0, 8'h00, 1'b1); repeat (3) tick();

    // DEPTH=2, continuous source, sink alternating 0/1: accepts on cycles 0,1,2,4,6,...
    for (int k = 0; k < 7; k++) exp_q[2].push_back(8'(8'h40 + k));
    for (int k = 0; k < 12; k++) begin
      idx = (k < 3) ? k : 3 + (k - 3) / 2;
      drive(2, 1'b1, 8'(8'h40 + idx), (k % 2) == 1);
      tick();
    end
    drive(2, 1'b0, 8'h00, 1'b1); repeat (4) tick();

    // DEPTH=3, random valid/ready; each word is held until it is accepted.
    for (int i = 0; i < N_RAND; i++) exp_q[1].push_back(rand_word(i));
    idx = 0;
    while (idx < N_RAND) begin
      drive(1, 1'($urandom_range(0, 1)), rand_word(idx), 1'($urandom_range(0, 1)));
      @(negedge clk);
      if (s_tvalid[1] && s_tready[1]) idx++;
      tick();
    end
    drive(1, 1'b0, 8'h00, 1'b1); repeat (8) tick();

    done = 1'b1;
  end

endmodule

// File: doc/axis_fifo_reg.md
Name: axis_fifo_reg

Overview:
- Parametrised successor of the two-entry AXI-stream copy register.
- Moves words from s_* to m_* in strict FIFO order, one transfer per clock at full throughput.
- Holds up to DEPTH words: one output register plus a DEPTH-1 entry ring buffer.
- All outputs are registered, including s_tready, m_tvalid and the occupancy count, so the block can act as an elastic timing-closure buffer between stream stages.

Parameters:
- DATA_WIDTH, 8: payload width in bits.
- DEPTH, 4: total capacity in words. Any integer >= 2, not restricted to powers of two. DEPTH=2 reproduces the copy-register behaviour.
- COUNT_WIDTH, $clog2(DEPTH+1): width of the count output. Derived; not to be overridden.

Ports:
- clock, input, 1: sole clock, rising edge.
- reset, input, 1: synchronous, active-high reset. Carries the attribute X_INTERFACE_PARAMETER "POLARITY ACTIVE_HIGH".
- s_tdata, input, DATA_WIDTH: input payload.
- s_tvalid, input, 1: input valid.
- s_tready, output reg, 1: input ready, registered.
- m_tdata, output reg, DATA_WIDTH: output payload, registered.
- m_tvalid, output reg, 1: output valid, registered.
- m_tready, input, 1: output ready.
- count, output reg, COUNT_WIDTH: words currently held (output register plus ring), range 0..DEPTH.

Behaviour:
- Transfers:
  - push = s_tvalid && s_tready
  - pop = m_tvalid && m_tready
  - Both are sampled on the rising edge.
- Reset (synchronous, takes priority over everything):
  - count=0, m_tvalid=0, s_tready=1, ring pointers=0.
  - m_tdata and ring contents are not reset; m_tdata is don't-care while m_tvalid=0.
  - Reset asserted mid-stream discards all held words, with no pop reported.
- Count update: count_next = count + push - pop. Push and pop in the same cycle leave count unchanged.
- Registered flags: s_tready <= (count_next < DEPTH); m_tvalid <= (count_next > 0).
- Invariants:
  - m_tvalid == (count != 0)
  - s_tready == (count != DEPTH)
  - !s_tready implies m_tvalid
- Output register load, when (!m_tvalid || m_tready):
  - If the ring is non-empty, load the ring head and advance the read pointer.
  - Else if push, load s_tdata directly (bypass).
  - Else hold the current value.
- Ring write: on push, unless the word bypasses straight into the output register, write s_tdata at the write pointer and advance it.
- Pointers:
  - Range 0..DEPTH-2.
  - Wrap explicitly from DEPTH-2 to 0; no reliance on binary overflow.
  - When DEPTH=2 the ring has one entry and the pointers stay at 0.
- Latency and throughput:
  - A word pushed into an empty FIFO appears on m_tvalid/m_tdata the cycle after acceptance (1-cycle latency).
  - In steady state (count=1) with both sides active, one word per clock.
- Full: s_tready=0. A pop while full raises s_tready in the following cycle; one bubble on input is inherent to registering s_tready.
- Empty: m_tvalid=0, and m_tready is ignored.
- Stability: while m_tvalid=1 && m_tready=0, m_tdata must not change. The AXI-stream no-change-under-stall rule applies.
- Input-side requirement: an upstream deassertion of s_tvalid while s_tready=0 is legal; the block places no requirement on s_tdata stability when no push occurs.
- No combinational path from any input to any output.

Test Plan:
- Reset then push 0x11, 0x22, 0x33 with m_tready=1 → m_tdata reads 0x11, 0x22, 0x33 on consecutive cycles, each one cycle after its push; count never exceeds 1.
- DEPTH=4, m_tready=0, s_tvalid=1 with data 1..6 → exactly 1..4 accepted; s_tready=0 from the cycle after the 4th push; count=4; m_tdata=1 held stable.
- From full, m_tready=1 for 6 cycles with s_tvalid=1 carrying 5, 6 → output sequence 1, 2, 3, 4, 5, 6 in order; s_tready returns to 1 one cycle after the first pop.
- DEPTH=3, random s_tvalid/m_tready (50%), 10000 words → output equals input order across many pointer wraps; invariants hold every cycle; count matches a scoreboard model.
- Fill with 3 words, assert reset for one cycle mid-transfer → next cycle count=0, m_tvalid=0, s_tready=1; a subsequent push of 0xAA emerges as the first output word.
- DEPTH=2, alternating m_tready with continuous input → cycle-identical to the two-entry copy register's s_tready/m_tvalid/m_tdata traces.
